pwm_audio_out: RTL and testbench



---
 rtl/pwm_audio_out.sv | 144 ++++++++++++++
 tb/tb_pwm_audio_out.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_out.sv
// ============================================================================
// pwm_audio_out : mixed-sample capture, 10-bit duty conversion, frame-locked
//                 PWM driver with underrun tracking and mute.
// Optional macro PWM_NOISE_SHAPE_EN adds first-order error feedback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_audio_out (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [9:0]  master_count_in,
  input  logic [15:0] sample_in,
  input  logic        sample_valid_in,
  input  logic        mute_in,
  output logic        pwm_out,
  output logic [9:0]  duty_out,
  output logic        running_out,
  output logic [7:0]  underrun_count_out
);

  localparam logic [9:0] C_MID_DUTY  = 10'h200;
  localparam logic [9:0] C_LOAD_CNT  = 10'h3FF;
  localparam logic [7:0] C_UNDER_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_pending;
  logic        r_fresh;
  logic [9:0]  r_duty;
  logic [9:0]  w_duty_nxt;
  logic [7:0]  r_underrun;
  logic [7:0]  w_underrun_nxt;
  logic        r_pwm;
  logic        w_load;
  logic [9:0]  w_conv;

  assign w_load = (master_count_in == C_LOAD_CNT);

`ifdef PWM_NOISE_SHAPE_EN
  logic [15:0] w_offset;
  logic [16:0] w_sum;
  logic [5:0]  w_conv_err;
  logic [5:0]  r_err;
  logic        w_err_upd;

  assign w_offset   = r_pending ^ 16'h8000;
  assign w_sum      = {1'b0, w_offset} + {11'h000, r_err};
  assign w_conv     = w_sum[16] ? 10'h3FF : w_sum[15:6];
  assign w_conv_err = w_sum[16] ? 6'h3F : w_sum[5:0];

  // Error only advances when a real conversion is taken (not the IDLE hold).
  assign w_err_upd  = w_load && !mute_in && ((r_state != ST_IDLE) || r_fresh);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_err <= 6'h00;
    end else if (w_load && mute_in) begin
      r_err <= 6'h00;
    end else if (w_err_upd) begin
      r_err <= w_conv_err;
    end
  end
`else
  logic w_unused_lsbs;

  // Flipping the sign bit of the top ten bits is the offset-binary duty.
  assign w_conv        = r_pending[15:6] ^ 10'h200;
  assign w_unused_lsbs = &{1'b0, r_pending[5:0]};
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_duty_nxt     = r_duty;
    w_underrun_nxt = r_underrun;
    if (w_load) begin
      w_duty_nxt = w_conv;
      case (r_state)
        ST_IDLE: begin
          if (r_fresh) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_duty_nxt = C_MID_DUTY;
          end
        end
        ST_RUN, ST_STALE: begin
          if (r_fresh) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_STALE;
            if (r_underrun != C_UNDER_MAX) begin
              w_underrun_nxt = r_underrun + 8'd1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (mute_in) begin
        w_duty_nxt = C_MID_DUTY;
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state    <= ST_IDLE;
      r_duty     <= C_MID_DUTY;
      r_underrun <= 8'h00;
      r_pwm      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_duty     <= w_duty_nxt;
      r_underrun <= w_underrun_nxt;
      r_pwm      <= (master_count_in < r_duty);
    end
  end

  // A strobe coincident with a load still leaves fresh set.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_pending <= 16'h0000;
      r_fresh   <= 1'b0;
    end else if (sample_valid_in) begin
      r_pending <= sample_in;
      r_fresh   <= 1'b1;
    end else if (w_load) begin
      r_fresh   <= 1'b0;
    end
  end

  assign pwm_out            = r_pwm;
  assign duty_out           = r_duty;
  assign running_out        = (r_state == ST_RUN);
  assign underrun_count_out = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_pwm_audio_out.sv
// ============================================================================
// tb_pwm_audio_out : self-checking bench for pwm_audio_out with a frame-level
//                    reference model. Honours PWM_NOISE_SHAPE_EN like the DUT.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pwm_audio_out;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [9:0]  master_count_in = 10'd0;
  logic [15:0] sample_in = 16'd0;
  logic        sample_valid_in = 1'b0;
  logic        mute_in = 1'b0;
  logic        pwm_out;
  logic [9:0]  duty_out;
  logic        running_out;
  logic [7:0]  underrun_count_out;

  pwm_audio_out dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .master_count_in    (master_count_in),
    .sample_in          (sample_in),
    .sample_valid_in    (sample_valid_in),
    .mute_in            (mute_in),
    .pwm_out            (pwm_out),
    .duty_out           (duty_out),
    .running_out        (running_out),
    .underrun_count_out (underrun_count_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;
  logic [9:0] cnt = 10'd0;

  // Reference model: one sample slot, a fresh flag, and whether playback has
  // ever started; duty is derived with integer arithmetic.
  logic [15:0] m_pending;
  bit          m_fresh;
  bit          m_started;
  bit          m_run;
  int          m_duty;
  int          m_err;
  int          m_under;

  task automatic model_reset();
    m_pending = 16'd0; m_fresh = 0; m_started = 0; m_run = 0;
    m_duty = 512; m_err = 0; m_under = 0;
  endtask

  task automatic model_load(input bit mute);
    int v;
    int s;
    v = int'($signed(m_pending)) + 32768;
    if (mute) begin
      m_duty = 512; m_err = 0;
    end else if (m_started || m_fresh) begin
`ifdef PWM_NOISE_SHAPE_EN
      s = v + m_err;
      if (s > 65535) begin m_duty = 1023; m_err = 63; end
      else begin m_duty = s / 64; m_err = s % 64; end
`else
      s = v;
      m_duty = s / 64;
`endif
    end else begin
      m_duty = 512;
    end
    if (m_fresh) begin
      m_started = 1; m_run = 1;
    end else if (m_started) begin
      m_run = 0;
      if (m_under < 255) m_under++;
    end
    m_fresh = 0;
  endtask

  task automatic cycle(input bit v, input logic [15:0] s, input bit m, input bit rst,
                       output bit loaded, output bit hi);
    @(negedge clk_in);
    master_count_in = cnt;
    sample_valid_in = v;
    sample_in       = v ? s : 16'($urandom);
    mute_in         = m;
    reset_in        = rst;
    @(posedge clk_in);
    loaded = !rst && (cnt == 10'h3FF);
    if (rst) model_reset();
    else begin
      if (loaded) model_load(m);
      if (v) begin m_pending = s; m_fresh = 1; end
    end
    #1;
    hi  = pwm_out;
    cnt = cnt + 10'd1;
  endtask

  // Runs up to and including the next load; hi = PWM high clocks seen,
  // dprev = model duty that was active across the window.
  task automatic run_frame(input int at, input logic [15:0] s, input int at2,
                           input logic [15:0] s2, input bit m,
                           output int hi, output int dprev);
    bit ld;
    bit h;
    bit v;
    hi = 0; ld = 0; dprev = m_duty;
    while (!ld) begin
      v = (int'(cnt) == at) || (int'(cnt) == at2);
      cycle(v, (int'(cnt) == at2) ? s2 : s, m, 1'b0, ld, h);
      if (h) hi++;
    end
  endtask

  task automatic do_reset();
    bit ld;
    bit h;
    int hi;
    int dp;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, 1'b0, 1'b1, ld, h);
    run_frame(-1, 16'd0, -1, 16'd0, 1'b0, hi, dp);
  endtask

  task automatic test_reset();
    bit ld;
    bit h;
    int hi;
    int dp;
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'd0, 1'b0, 1'b1, ld, h);
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL rst_pwm: got %0d want 0", pwm_out); end
    total++; if (duty_out !== 10'd512) begin bad++; $display("FAIL rst_duty: got %0d want 512", duty_out); end
    total++; if (running_out !== 1'b0) begin bad++; $display("FAIL rst_running: got %0d want 0", running_out); end
    total++; if (underrun_count_out !== 8'd0) begin bad++; $display("FAIL rst_under: got %0d want 0", underrun_count_out); end
    run_frame(-1, 16'd0, -1, 16'd0, 1'b0, hi, dp);
    for (int f = 0; f < 3; f++) begin
      run_frame(-1, 16'd0, -1, 16'd0, 1'b0, hi, dp);
      total++; if (hi != 512) begin bad++; $display("FAIL idle_high f%0d: got %0d want 512", f, hi); end
      total++; if (duty_out !== 10'd512) begin bad++; $display("FAIL idle_duty f%0d: got %0d want 512", f, duty_out); end
      total++; if (running_out !== 1'b0) begin bad++; $display("FAIL idle_running f%0d: got %0d want 0", f, running_out); end
      total++; if (underrun_count_out !== 8'd0) begin bad++; $display("FAIL idle_under f%0d: got %0d want 0", f, underrun_count_out); end
    end
  endtask

  task automatic test_full_scale();
    int hi;
    int dp;
    do_reset();
    run_frame(16, 16'h7FFF, -1, 16'd0, 1'b0, hi, dp);
    total++; if (duty_out !== 10'd1023) begin bad++; $display("FAIL fs_duty_max: got %0d want 1023", duty_out); end
    total++; if (running_out !== 1'b1) begin bad++; $display("FAIL fs_running: got %0d want 1", running_out); end
    run_frame(200, 16'h8000, -1, 16'd0, 1'b0, hi, dp);
    total++; if (hi != 1023) begin bad++; $display("FAIL fs_high_max: got %0d want 1023", hi); end
    total++; if (duty_out !== 10'd0) begin bad++; $display("FAIL fs_duty_min: got %0d want 0", duty_out); end
    run_frame(300, 16'h8000, -1, 16'd0, 1'b0, hi, dp);
    total++; if (hi != 0) begin bad++; $display("FAIL fs_high_min: got %0d want 0", hi); end
  endtask

  task automatic test_underrun();
    int hi;
    int dp;
    do_reset();
    run_frame(40, 16'h4000, -1, 16'd0, 1'b0, hi, dp);
    total++; if (duty_out !== 10'd768) begin bad++; $display("FAIL ur_duty: got %0d want 768", duty_out); end
    for (int f = 1; f <= 3; f++) begin
      run_frame(-1, 16'd0, -1, 16'd0, 1'b0, hi, dp);
      total++; if (duty_out !== 10'd768) begin bad++; $display("FAIL ur_hold_duty f%0d: got %0d want 768", f, duty_out); end
      total++; if (running_out !== 1'b0) begin bad++; $display("FAIL ur_stale f%0d: got %0d want 0", f, running_out); end
      total++; if (underrun_count_out !== 8'(f)) begin bad++; $display("FAIL ur_count f%0d: got %0d want %0d", f, underrun_count_out, f); end
    end
    run_frame(500, 16'h4000, -1, 16'd0, 1'b0, hi, dp);
    total++; if (running_out !== 1'b1) begin bad++; $display("FAIL ur_resume: got %0d want 1", running_out); end
    total++; if (underrun_count_out !== 8'd3) begin bad++; $display("FAIL ur_count_resume: got %0d want 3", underrun_count_out); end
  endtask

  task automatic test_coincident();
    int hi;
    int dp;
    do_reset();
    run_frame(10, 16'h1000, 1023, 16'hC000, 1'b0, hi, dp);
    total++; if (duty_out !== 10'd576) begin bad++; $display("FAIL co_old_sample: got %0d want 576", duty_out); end
    run_frame(-1, 16'd0, -1, 16'd0, 1'b0, hi, dp);
    total++; if (duty_out !== 10'd256) begin bad++; $display("FAIL co_new_sample: got %0d want 256", duty_out); end
    total++; if (running_out !== 1'b1) begin bad++; $display("FAIL co_running: got %0d want 1", running_out); end
    total++; if (underrun_count_out !== 8'd0) begin bad++; $display("FAIL co_under: got %0d want 0", underrun_count_out); end
  endtask

  task automatic test_mute();
    int hi;
    int dp;
    do_reset();
    run_frame(100, 16'h7FFF, -1, 16'd0, 1'b0, hi, dp);
    run_frame(100, 16'h7FFF, -1, 16'd0, 1'b1, hi, dp);
    total++; if (duty_out !== 10'd512) begin bad++; $display("FAIL mute_duty: got %0d want 512", duty_out); end
    total++; if (running_out !== 1'b1) begin bad++; $display("FAIL mute_running: got %0d want 1", running_out); end
    run_frame(100, 16'h7FFF, -1, 16'd0, 1'b0, hi, dp);
    total++; if (hi != 512) begin bad++; $display("FAIL mute_high: got %0d want 512", hi); end
    total++; if (duty_out !== 10'd1023) begin bad++; $display("FAIL unmute_duty: got %0d want 1023", duty_out); end
  endtask

  task automatic test_noise_shape();
    int hi;
    int dp;
`ifdef PWM_NOISE_SHAPE_EN
    int exp_d[4] = '{512, 513, 512, 513};
`else
    int exp_d[4] = '{512, 512, 512, 512};
`endif
    do_reset();
    for (int f = 0; f < 4; f++) begin
      run_frame(100, 16'h0020, -1, 16'd0, 1'b0, hi, dp);
      total++; if (duty_out !== 10'(exp_d[f])) begin bad++; $display("FAIL ns_duty f%0d: got %0d want %0d", f, duty_out, exp_d[f]); end
    end
  endtask

  task automatic test_random();
    int hi;
    int dp;
    int at;
    int at2;
    bit m;
    logic [15:0] s;
    logic [15:0] s2;
    do_reset();
    for (int f = 0; f < 14; f++) begin
      at  = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 1023)) : -1;
      if (f == 6) at = 1023;
      at2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : -1;
      s   = 16'($urandom);
      s2  = 16'($urandom);
      m   = ($urandom_range(0, 4) == 0);
      run_frame(at, s, at2, s2, m, hi, dp);
      total++; if (hi != dp) begin bad++; $display("FAIL rnd_high f%0d: got %0d want %0d", f, hi, dp); end
      total++; if (duty_out !== 10'(m_duty)) begin bad++; $display("FAIL rnd_duty f%0d: got %0d want %0d", f, duty_out, m_duty); end
      total++; if (running_out !== m_run) begin bad++; $display("FAIL rnd_running f%0d: got %0d want %0d", f, running_out, m_run); end
      total++; if (underrun_count_out !== 8'(m_under)) begin bad++; $display("FAIL rnd_under f%0d: got %0d want %0d", f, underrun_count_out, m_under); end
    end
  endtask

  task automatic test_midframe_reset();
    bit ld;
    bit h;
    int hi;
    int dp;
    do_reset();
    run_frame(30, 16'h7FFF, -1, 16'd0, 1'b0, hi, dp);
    run_frame(-1, 16'd0, -1, 16'd0, 1'b0, hi, dp);
    for (int i = 0; i < 300; i++) cycle(i == 50, 16'h5555, 1'b0, 1'b0, ld, h);
    #2 reset_in = 1'b1;
    #1;
    total++; if (duty_out !== 10'd512) begin bad++; $display("FAIL mr_duty: got %0d want 512", duty_out); end
    total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL mr_pwm: got %0d want 0", pwm_out); end
    total++; if (running_out !== 1'b0) begin bad++; $display("FAIL mr_running: got %0d want 0", running_out); end
    total++; if (underrun_count_out !== 8'd0) begin bad++; $display("FAIL mr_under: got %0d want 0", underrun_count_out); end
    model_reset();
    for (int i = 0; i < 2; i++) cycle(1'b0, 16'd0, 1'b0, 1'b1, ld, h);
    run_frame(-1, 16'd0, -1, 16'd0, 1'b0, hi, dp);
    total++; if (duty_out !== 10'd512) begin bad++; $display("FAIL mr_idle_duty: got %0d want 512", duty_out); end
    total++; if (running_out !== 1'b0) begin bad++; $display("FAIL mr_idle_running: got %0d want 0", running_out); end
    run_frame(70, 16'h2000, -1, 16'd0, 1'b0, hi, dp);
    total++; if (duty_out !== 10'd640) begin bad++; $display("FAIL mr_restart_duty: got %0d want 640", duty_out); end
    total++; if (running_out !== 1'b1) begin bad++; $display("FAIL mr_restart_running: got %0d want 1", running_out); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_scale();
    test_underrun();
    test_coincident();
    test_mute();
    test_noise_shape();
    test_random();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
